// File: rtl/i2s_audio.sv
// ---------------------------------------------------------------------------
// i2s_audio
//
// Digital audio data port for a WM8731 codec running as I2S master with
// DATA_W-bit words. The codec drives BCLK and both LRCKs; this block
// oversamples them in the clk domain (f_clk >= 10 x f_BCLK), deserialises
// ADC samples into parallel stereo words, and serialises playback words onto
// DACDAT from a one-deep holding buffer.
//
// Optional feature macro: I2S_LOOPBACK_EN
//   Defined     : every recorded frame is written into the playback buffer,
//                 the external play_* handshake is ignored, play_ready = 0.
//   Not defined : playback frames come from the valid/ready handshake.
//
// Ports
//   clk            system clock, all logic on its rising edge
//   reset          synchronous, active-low reset
//   aud_bclk       codec bit clock (asynchronous)
//   aud_adclrck    ADC frame clock, 0 = left
//   aud_adcdat     ADC serial data
//   aud_daclrck    DAC frame clock, 0 = left
//   aud_dacdat     DAC serial data
//   rec_left/right last complete recorded stereo frame
//   rec_valid      one-cycle pulse when rec_left/rec_right update
//   play_left/right, play_valid, play_ready   playback handshake
//   play_underrun  sticky: a DAC frame started with the buffer empty
// ---------------------------------------------------------------------------
module i2s_audio #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aud_bclk,
    input  logic              aud_adclrck,
    input  logic              aud_adcdat,
    input  logic              aud_daclrck,
    output logic              aud_dacdat,
    output logic [DATA_W-1:0] rec_left,
    output logic [DATA_W-1:0] rec_right,
    output logic              rec_valid,
    input  logic [DATA_W-1:0] play_left,
    input  logic [DATA_W-1:0] play_right,
    input  logic              play_valid,
    output logic              play_ready,
    output logic              play_underrun
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_LEFT  = 2'd1,
        S_RIGHT = 2'd2
    } chan_e;

    // -----------------------------------------------------------------------
    // Input synchronisers. All four pins see the same two-flop delay so the
    // synced LRCK/data are coherent with the synced BCLK edge.
    // -----------------------------------------------------------------------
    logic [1:0] bclk_sync, adclr_sync, adcdat_sync, daclr_sync;
    logic       bclk_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            bclk_sync   <= '0;
            adclr_sync  <= '0;
            adcdat_sync <= '0;
            daclr_sync  <= '0;
            bclk_d      <= 1'b0;
        end else begin
            bclk_sync   <= {bclk_sync[0], aud_bclk};
            adclr_sync  <= {adclr_sync[0], aud_adclrck};
            adcdat_sync <= {adcdat_sync[0], aud_adcdat};
            daclr_sync  <= {daclr_sync[0], aud_daclrck};
            bclk_d      <= bclk_sync[1];
        end
    end

    logic bclk_s, adclr_s, adcdat_s, daclr_s;
    logic bclk_rise, bclk_fall;

    assign bclk_s    = bclk_sync[1];
    assign adclr_s   = adclr_sync[1];
    assign adcdat_s  = adcdat_sync[1];
    assign daclr_s   = daclr_sync[1];
    assign bclk_rise = bclk_s & ~bclk_d;
    assign bclk_fall = ~bclk_s & bclk_d;

    // -----------------------------------------------------------------------
    // LRCK history, sampled on BCLK rising edges only. The *_seen flag keeps
    // the first sample after reset from being mistaken for a frame edge, so
    // both FSMs resynchronise on a genuine LRCK transition.
    // -----------------------------------------------------------------------
    logic adc_lr_prev, adc_lr_seen, dac_lr_prev, dac_lr_seen;
    logic adc_edge, dac_edge;

    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_lr_prev <= 1'b0;
            adc_lr_seen <= 1'b0;
            dac_lr_prev <= 1'b0;
            dac_lr_seen <= 1'b0;
        end else if (bclk_rise) begin
            adc_lr_prev <= adclr_s;
            adc_lr_seen <= 1'b1;
            dac_lr_prev <= daclr_s;
            dac_lr_seen <= 1'b1;
        end
    end

    assign adc_edge = bclk_rise & adc_lr_seen & (adclr_s != adc_lr_prev);
    assign dac_edge = bclk_rise & dac_lr_seen & (daclr_s != dac_lr_prev);

    // -----------------------------------------------------------------------
    // ADC frame FSM
    // -----------------------------------------------------------------------
    chan_e adc_state, adc_next;

    always_ff @(posedge clk) begin
        if (!reset) adc_state <= S_WAIT;
        else        adc_state <= adc_next;
    end

    always_comb begin
        adc_next = adc_state;
        if (adc_edge) adc_next = adclr_s ? S_RIGHT : S_LEFT;
    end

    // ADC datapath. The frame-edge rise is the I2S delay slot, so shifting
    // starts on the following rise.
    logic [CNT_W-1:0]  adc_cnt;
    logic [DATA_W-1:0] adc_sr, left_stage, adc_word;
    logic              left_have, adc_shift, adc_last;

    assign adc_word  = {adc_sr[DATA_W-2:0], adcdat_s};
    assign adc_shift = bclk_rise & ~adc_edge & (adc_state != S_WAIT) & (adc_cnt < CNT_MAX);
    assign adc_last  = adc_shift & (adc_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            adc_cnt    <= '0;
            adc_sr     <= '0;
            left_stage <= '0;
            left_have  <= 1'b0;
            rec_left   <= '0;
            rec_right  <= '0;
            rec_valid  <= 1'b0;
        end else begin
            rec_valid <= 1'b0;
            if (adc_edge) begin
                adc_cnt <= '0;
                // A new left half invalidates any stale, unpaired left word.
                if (!adclr_s) left_have <= 1'b0;
            end else if (adc_shift) begin
                adc_sr  <= adc_word;
                adc_cnt <= adc_cnt + 1'b1;
                if (adc_last) begin
                    if (adc_state == S_LEFT) begin
                        left_stage <= adc_word;
                        left_have  <= 1'b1;
                    end else if (left_have) begin
                        rec_left  <= left_stage;
                        rec_right <= adc_word;
                        rec_valid <= 1'b1;
                        left_have <= 1'b0;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // DAC frame FSM
    // -----------------------------------------------------------------------
    chan_e dac_state, dac_next;

    always_ff @(posedge clk) begin
        if (!reset) dac_state <= S_WAIT;
        else        dac_state <= dac_next;
    end

    always_comb begin
        dac_next = dac_state;
        if (dac_edge) dac_next = daclr_s ? S_RIGHT : S_LEFT;
    end

    // -----------------------------------------------------------------------
    // Playback buffer source selection
    // -----------------------------------------------------------------------
    logic              buf_full, rdy_en, buf_wr;
    logic [DATA_W-1:0] wr_left, wr_right;

`ifdef I2S_LOOPBACK_EN
    logic unused_play;
    assign unused_play = ^{play_left, play_right, play_valid, rdy_en};
    assign buf_wr      = rec_valid;
    assign wr_left     = rec_left;
    assign wr_right    = rec_right;
    assign play_ready  = 1'b0;
`else
    // rdy_en holds play_ready low while in reset and lets it rise on the
    // first cycle after reset is released.
    assign play_ready  = rdy_en & ~buf_full;
    assign buf_wr      = play_valid & play_ready;
    assign wr_left     = play_left;
    assign wr_right    = play_right;
`endif

    // -----------------------------------------------------------------------
    // DAC datapath and buffer. A write coinciding with a left-start unload
    // stores the new frame while the unload takes the previous contents
    // (non-blocking reads of buf_*), so the buffer stays full.
    // -----------------------------------------------------------------------
    logic              left_start;
    logic [DATA_W-1:0] buf_left, buf_right, right_latch, dac_sr;
    logic [CNT_W-1:0]  dac_cnt;

    assign left_start = dac_edge & ~daclr_s;

    always_ff @(posedge clk) begin
        if (!reset) begin
            rdy_en        <= 1'b0;
            buf_full      <= 1'b0;
            buf_left      <= '0;
            buf_right     <= '0;
            right_latch   <= '0;
            dac_sr        <= '0;
            dac_cnt       <= '0;
            aud_dacdat    <= 1'b0;
            play_underrun <= 1'b0;
        end else begin
            rdy_en <= 1'b1;

            if (buf_wr) begin
                buf_left  <= wr_left;
                buf_right <= wr_right;
            end

            if (buf_wr)          buf_full <= 1'b1;
            else if (left_start) buf_full <= 1'b0;

            if (left_start) begin
                dac_cnt <= '0;
                if (buf_full) begin
                    dac_sr      <= buf_left;
                    right_latch <= buf_right;
                end else begin
                    dac_sr        <= '0;
                    right_latch   <= '0;
                    play_underrun <= 1'b1;
                end
            end else if (dac_edge) begin
                dac_cnt <= '0;
                dac_sr  <= right_latch;
            end else if (bclk_fall) begin
                if (dac_state == S_WAIT) begin
                    aud_dacdat <= 1'b0;
                end else if (dac_cnt < CNT_MAX) begin
                    aud_dacdat <= dac_sr[DATA_W-1];
                    dac_sr     <= {dac_sr[DATA_W-2:0], 1'b0};
                    dac_cnt    <= dac_cnt + 1'b1;
                end else begin
                    aud_dacdat <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_audio.sv
// ---------------------------------------------------------------------------
// tb_i2s_audio
//
// Bench for i2s_audio (DATA_W = 16). A behavioural codec emits I2S frames of
// 20 BCLK slots per channel (delay slot, 16 data bits, 3 pad bits) with
// BCLK = clk/12, and captures DACDAT just before each rising BCLK. A small
// playback-buffer model (pending frame + full flag + underrun flag) supplies
// expected DAC words for the randomized part; directed frames use a table.
// Build with I2S_LOOPBACK_EN defined to exercise the loopback variant.
// ---------------------------------------------------------------------------
module tb_i2s_audio;

    localparam int W     = 16;
    localparam int SLOTS = 20;
    localparam int HALF  = SLOTS * 120;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         aud_bclk = 1'b1, aud_adclrck = 1'b1, aud_adcdat = 1'b0, aud_daclrck = 1'b1;
    logic         aud_dacdat;
    logic [W-1:0] rec_left, rec_right;
    logic         rec_valid;
    logic [W-1:0] play_left = '0, play_right = '0;
    logic         play_valid = 1'b0;
    logic         play_ready, play_underrun;

    always #5 clk = ~clk;

    i2s_audio #(.DATA_W(W)) dut (
        .clk(clk), .reset(reset),
        .aud_bclk(aud_bclk), .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
        .aud_daclrck(aud_daclrck), .aud_dacdat(aud_dacdat),
        .rec_left(rec_left), .rec_right(rec_right), .rec_valid(rec_valid),
        .play_left(play_left), .play_right(play_right), .play_valid(play_valid),
        .play_ready(play_ready), .play_underrun(play_underrun)
    );

    int total = 0;
    int bad   = 0;
    int rec_cnt = 0;

    always @(negedge clk) if (rec_valid) rec_cnt <= rec_cnt + 1;

    // Playback model
    logic [W-1:0] pend_l, pend_r, exp_dl, exp_dr, got_l, got_r;
    logic         pend_full = 1'b0, exp_under = 1'b0;
    int           rec_delta;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // One channel half: 20 BCLK slots, data in slots 1..16, DAC sampled
    // just before each rising BCLK of slots 1..16.
    task automatic half(input logic lr, input logic [W-1:0] w, output logic [W-1:0] got);
        got = '0;
        for (int s = 0; s < SLOTS; s++) begin
            aud_bclk    = 1'b0;
            aud_adclrck = lr;
            aud_daclrck = lr;
            if (s >= 1 && s <= W) aud_adcdat = w[W-s];
            else                  aud_adcdat = 1'($urandom_range(0, 1));
            #59;
            if (s >= 1 && s <= W) got[W-s] = aud_dacdat;
            #1 aud_bclk = 1'b1;
            #60;
        end
    endtask

    task automatic frame(input logic [W-1:0] al, input logic [W-1:0] ar);
        int c0;
        if (pend_full) begin
            exp_dl = pend_l;
            exp_dr = pend_r;
        end else begin
            exp_dl    = '0;
            exp_dr    = '0;
            exp_under = 1'b1;
        end
        pend_full = 1'b0;
        c0 = rec_cnt;
        half(1'b0, al, got_l);
        half(1'b1, ar, got_r);
        rec_delta = rec_cnt - c0;
    endtask

    task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
        bit ok = 1'b0;
        @(negedge clk);
        play_left  = l;
        play_right = r;
        play_valid = 1'b1;
        for (int i = 0; i < 5000 && !ok; i++) begin
            if (play_ready) begin
                @(posedge clk);
                #1 ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        play_valid = 1'b0;
        chk("offer_accepted", 32'(ok), 1);
        if (ok) begin
            pend_l    = l;
            pend_r    = r;
            pend_full = 1'b1;
            @(negedge clk);
            chk("ready_low_after_xfer", 32'(play_ready), 0);
        end
    endtask

    typedef struct {
        logic [W-1:0] al, ar;
        bit           off;
        logic [W-1:0] pl, pr;
        logic [W-1:0] dl, dr;
        bit           under;
    } vec_t;

    vec_t tbl[4];

    initial begin
        logic [W-1:0] dummy;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dacdat",   32'(aud_dacdat), 0);
        chk("rst_rec_valid", 32'(rec_valid), 0);
        chk("rst_rec_left",  32'(rec_left), 0);
        chk("rst_rec_right", 32'(rec_right), 0);
        chk("rst_underrun",  32'(play_underrun), 0);
        chk("rst_ready",     32'(play_ready), 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
`ifdef I2S_LOOPBACK_EN
        chk("lb_ready_after_rst", 32'(play_ready), 0);
        play_valid = 1'b1;
        play_left  = 16'hFFFF;
        play_right = 16'hEEEE;
        half(1'b1, 16'h0, dummy);
        chk("lb_wait_dac_zero", 32'(dummy), 0);
        frame(16'h1234, 16'h5678);
        chk("lb_rec_cnt", rec_delta, 1);
        chk("lb_rec_left", 32'(rec_left), 32'h1234);
        chk("lb_rec_right", 32'(rec_right), 32'h5678);
        chk("lb_first_dac_l", 32'(got_l), 0);
        chk("lb_first_dac_r", 32'(got_r), 0);
        chk("lb_underrun", 32'(play_underrun), 1);
        chk("lb_ready", 32'(play_ready), 0);
        frame(16'hAAAA, 16'h5555);
        chk("lb_dac_l", 32'(got_l), 32'h1234);
        chk("lb_dac_r", 32'(got_r), 32'h5678);
        chk("lb_ready2", 32'(play_ready), 0);
        frame(16'h0, 16'h0);
        chk("lb_dac_l2", 32'(got_l), 32'hAAAA);
        chk("lb_dac_r2", 32'(got_r), 32'h5555);
        chk("lb_underrun_sticky", 32'(play_underrun), 1);
        play_valid = 1'b0;
`else
        chk("ready_after_rst", 32'(play_ready), 1);

        // Buffer a frame before any LRCK edge, then an idle right half.
        offer(16'h8001, 16'h7FFE);
        half(1'b1, 16'($urandom), dummy);
        chk("wait_dac_zero", 32'(dummy), 0);

        tbl[0] = '{16'hA5C3, 16'h0F0F, 1'b1, 16'h1111, 16'h2222, 16'h8001, 16'h7FFE, 1'b0};
        tbl[1] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'h0000, 16'h1111, 16'h2222, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b1, 16'h3C3C, 16'hC3C3, 16'h0000, 16'h0000, 1'b1};
        tbl[3] = '{16'hFFFF, 16'h8000, 1'b1, 16'h5A5A, 16'hA5A5, 16'h3C3C, 16'hC3C3, 1'b1};

        for (int i = 0; i < 4; i++) begin
            fork
                frame(tbl[i].al, tbl[i].ar);
                begin
                    if (tbl[i].off) begin
                        #(HALF + 30);
                        offer(tbl[i].pl, tbl[i].pr);
                    end
                end
            join
            chk("tbl_rec_cnt",   rec_delta, 1);
            chk("tbl_rec_left",  32'(rec_left), 32'(tbl[i].al));
            chk("tbl_rec_right", 32'(rec_right), 32'(tbl[i].ar));
            chk("tbl_dac_left",  32'(got_l), 32'(tbl[i].dl));
            chk("tbl_dac_right", 32'(got_r), 32'(tbl[i].dr));
            chk("tbl_underrun",  32'(play_underrun), 32'(tbl[i].under));
        end

        // Offer held through left start while the buffer is full: the old
        // frame plays, the new one is captured right after the unload.
        fork
            frame(16'h0F0F, 16'hF0F0);
            offer(16'h1357, 16'h2468);
        join
        chk("hold_dac_left",  32'(got_l), 32'h5A5A);
        chk("hold_dac_right", 32'(got_r), 32'hA5A5);
        chk("hold_ready",     32'(play_ready), 0);
        frame(16'h4321, 16'h8765);
        chk("held_dac_left",  32'(got_l), 32'h1357);
        chk("held_dac_right", 32'(got_r), 32'h2468);
        chk("held_rec_left",  32'(rec_left), 32'h4321);

        // Reset for two cycles in the middle of a left word.
        fork
            frame(16'hCAFE, 16'hBEEF);
            begin
                #(8 * 120 + 30);
                @(negedge clk) reset = 1'b0;
                repeat (2) @(negedge clk);
                reset     = 1'b1;
                pend_full = 1'b0;
                exp_under = 1'b0;
            end
        join
        chk("mid_rst_rec_cnt",   rec_delta, 0);
        chk("mid_rst_rec_left",  32'(rec_left), 0);
        chk("mid_rst_rec_right", 32'(rec_right), 0);
        chk("mid_rst_underrun",  32'(play_underrun), 0);
        chk("mid_rst_dac_right", 32'(got_r), 0);
        offer(16'h9ABC, 16'hDEF0);
        frame(16'h6E6E, 16'h1D1D);
        chk("post_rst_rec_cnt",  rec_delta, 1);
        chk("post_rst_rec_left", 32'(rec_left), 32'h6E6E);
        chk("post_rst_rec_right", 32'(rec_right), 32'h1D1D);
        chk("post_rst_dac_left", 32'(got_l), 32'h9ABC);
        chk("post_rst_dac_right", 32'(got_r), 32'hDEF0);
        chk("post_rst_underrun", 32'(play_underrun), 0);

        // Randomized frames against the buffer model.
        for (int n = 0; n < 6; n++) begin
            logic [W-1:0] al, ar, pl, pr;
            bit off;
            al  = 16'($urandom);
            ar  = 16'($urandom);
            pl  = 16'($urandom);
            pr  = 16'($urandom);
            off = 1'($urandom_range(0, 1));
            fork
                frame(al, ar);
                begin
                    if (off) begin
                        #(HALF + 30);
                        offer(pl, pr);
                    end
                end
            join
            chk("rnd_rec_cnt",   rec_delta, 1);
            chk("rnd_rec_left",  32'(rec_left), 32'(al));
            chk("rnd_rec_right", 32'(rec_right), 32'(ar));
            chk("rnd_dac_left",  32'(got_l), 32'(exp_dl));
            chk("rnd_dac_right", 32'(got_r), 32'(exp_dr));
            chk("rnd_underrun",  32'(play_underrun), 32'(exp_under));
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_audio.md
# i2s_audio

Digital audio data port for the WM8731 codec, downstream of the I2C configurator. The configurator sets the codec to master mode, I2S format, 16-bit words. This block recovers the codec-driven BCLK/ADCLRCK/DACLRCK in the `clk` domain and deserialises ADC samples into parallel left/right words. It also serialises parallel playback words onto DACDAT through a one-deep holding buffer with a valid/ready handshake.

## Interface

- `DATA_W`, 16, word length per channel. Legal range 8–24 and must match the codec IWL setting.
- `clk`  in  1  system clock, all logic on its rising edge. f_clk ≥ 10 × f_BCLK.
- `reset`  in  1  synchronous, active-low reset.
- `aud_bclk`  in  1  codec bit clock, asynchronous to `clk`.
- `aud_adclrck`  in  1  ADC frame clock (0 = left).
- `aud_adcdat`  in  1  ADC serial data.
- `aud_daclrck`  in  1  DAC frame clock (0 = left).
- `aud_dacdat`  out  1  DAC serial data.
- `rec_left`, `rec_right`  out  DATA_W  last complete recorded stereo frame.
- `rec_valid`  out  1  one-`clk` pulse when `rec_left`/`rec_right` update.
- `play_left`, `play_right`  in  DATA_W  playback frame.
- `play_valid`  in  1  playback frame offered.
- `play_ready`  out  1  holding buffer empty. A transfer happens when `play_valid` && `play_ready`.
- `play_underrun`  out  1  sticky flag: a DAC frame started with the buffer empty.

## Operation

- **Input synchronisation:** `aud_bclk`, `aud_adclrck`, `aud_adcdat` and `aud_daclrck` each pass through two flops. A third flop on BCLK gives edge detection.
  - `bclk_rise` = synced 0→1.
  - `bclk_fall` = synced 1→0.
  - All four signals share the same delay.
- **LRCK sampling:** both LRCK signals are sampled only on `bclk_rise`. A "frame edge" is a rising-edge sample that differs from the previous rising-edge sample.
- **ADC frame FSM, states WAIT / LEFT / RIGHT:**
  - WAIT after reset. Leaves WAIT on the first frame edge, to LEFT if ADCLRCK = 0, otherwise RIGHT.
  - On each frame edge: switch channel and clear `bit_cnt`. That rising edge is the I2S delay slot and no data is captured.
  - On later `bclk_rise` with `bit_cnt` < DATA_W: shift `aud_adcdat` in MSB-first and increment `bit_cnt`. Bits beyond DATA_W are ignored.
  - When `bit_cnt` reaches DATA_W in LEFT, store the word in a left staging register.
  - When it reaches DATA_W in RIGHT, and a left word was captured earlier in the same frame, update `rec_left`/`rec_right` together and pulse `rec_valid`.
  - A right word without a preceding left word is discarded.
- **DAC frame FSM, states WAIT / LEFT / RIGHT:**
  - On a DACLRCK frame edge to 0 (left start):
    - If the buffer is full: load the left shift register from the buffer, latch the right word, and mark the buffer empty.
    - If the buffer is empty: load zeros for both channels and set `play_underrun`.
  - On a frame edge to 1: load the right shift register from the latched right word.
  - On each `bclk_fall` after a frame edge, while `bit_cnt` < DATA_W: drive the MSB on `aud_dacdat`, shift left, and increment. After DATA_W bits, drive 0.
  - In WAIT, `aud_dacdat` = 0.
- **Simultaneous events:** if a buffer write and a left-start unload fall on the same cycle, the unload takes the old contents and the new write is stored. Net result: the buffer stays full.

## Timing

- **Reset values:**
  - `aud_dacdat` = 0, `rec_left` = `rec_right` = 0, `rec_valid` = 0, `play_underrun` = 0, `play_ready` = 0.
  - Both FSMs go to WAIT and the buffer is empty.
  - `play_ready` rises on the first cycle after `reset` deasserts.
- **Edge latency:** a pin edge is seen as `bclk_rise`/`bclk_fall` 3 `clk` cycles later.
- **DAC data output:** `aud_dacdat` changes 1 cycle after `bclk_fall`, so within 4 `clk` cycles of the pin falling edge. It is stable before the next codec sampling edge, given the ratio ≥ 10.
- **Record output:** `rec_valid` asserts 1 cycle after the `bclk_rise` that captures the right LSB.
- **Playback handshake:** after a transfer, `play_ready` is low from the next cycle. It returns high 1 cycle after the unload at left start.
- **Reset mid-frame:** the partial frame is discarded and there is no `rec_valid`. Both FSMs resynchronise on the next frame edge.

## Configuration

- `I2S_LOOPBACK_EN` defined:
  - Each `rec_valid` writes `rec_left`/`rec_right` into the playback buffer, overwriting it if full.
  - `play_valid`, `play_left` and `play_right` are ignored and `play_ready` is held 0.
  - `play_underrun` still reports underrun, e.g. before the first recorded frame.
- Not defined: normal external handshake as described above.

## Test plan

- **Record:** DATA_W = 16, BCLK = clk/12, ADC sends L = 16'hA5C3, R = 16'h0F0F -> one `rec_valid` pulse with `rec_left` = A5C3 and `rec_right` = 0F0F. Trailing pad bits are ignored.
- **Playback:** offer 16'h8001 / 16'h7FFE before the first left start -> DACDAT carries 8001 then 7FFE MSB-first, each starting one BCLK after its LRCK edge. `play_ready` is 0 until unload, then 1.
- **Underrun:** no `play_valid` -> DACDAT all zeros and `play_underrun` = 1 and stays 1. Later valid frames play correctly and the flag remains set until reset.
- **Reset mid-frame:** assert `reset` for 2 cycles mid-left-word -> no `rec_valid` for that frame. The next full frame is captured correctly.
- **Simultaneous write/unload:** handshake in the same cycle as left start -> old frame plays, new frame is held, and `play_ready` = 0.
- **Loopback (`I2S_LOOPBACK_EN`):** ADC frame 1234/5678 -> DACDAT plays 1234/5678 in the following DAC frame. `play_ready` = 0 throughout.
